// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// State encoding and radix-4 Booth digit patterns live here.
package multdiv_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int MULT_STEPS_DEF = WIDTH_DEF / 2;
  localparam int DIV_STEPS_DEF  = WIDTH_DEF;
  localparam int CNT_W          = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MULT = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Booth triplets {b[i+1], b[i], b[i-1]} grouped by the digit they encode
  localparam logic [2:0] BOOTH_P1A = 3'b001;
  localparam logic [2:0] BOOTH_P1B = 3'b010;
  localparam logic [2:0] BOOTH_P2  = 3'b011;
  localparam logic [2:0] BOOTH_M2  = 3'b100;
  localparam logic [2:0] BOOTH_M1A = 3'b101;
  localparam logic [2:0] BOOTH_M1B = 3'b110;

  typedef struct packed {
    logic add;
    logic sub;
    logic shift_mcand;
  } booth_op_t;

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Request inputs from the core/datapath and control outputs to the datapath.
// master = requester/datapath side, slave = sequencer.
interface multdiv_sequencer_if;
  import multdiv_pkg::*;

  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [2:0]       booth_bits;
  logic             rem_negative;
  logic             divisor_zero;
  logic             mult_overflow;
  logic             load_operands;
  logic             op_is_div;
  logic             add;
  logic             sub;
  logic             shift_multiplicand;
  logic             shift_product;
  logic             div_restore;
  logic             quotient_bit;
  logic             busy;
  logic             data_resultRDY;
  logic             data_exception;
  logic [CNT_W-1:0] step_count;

  modport master (
    output ctrl_MULT, ctrl_DIV, booth_bits, rem_negative, divisor_zero, mult_overflow,
    input  load_operands, op_is_div, add, sub, shift_multiplicand, shift_product,
           div_restore, quotient_bit, busy, data_resultRDY, data_exception, step_count
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, booth_bits, rem_negative, divisor_zero, mult_overflow,
    output load_operands, op_is_div, add, sub, shift_multiplicand, shift_product,
           div_restore, quotient_bit, busy, data_resultRDY, data_exception, step_count
  );

endinterface

// File: rtl/multdiv_sequencer_booth_decoder.sv
// Radix-4 Booth digit decode: triplet -> add/sub and 2x multiplicand select.
// Purely combinational, zero latency.
module booth_decoder
  import multdiv_pkg::*;
(
  input  logic [2:0] booth_bits,
  output booth_op_t  op
);

  always_comb begin
    op = '0;
    case (booth_bits)
      BOOTH_P1A, BOOTH_P1B: op.add = 1'b1;
      BOOTH_P2: begin
        op.add         = 1'b1;
        op.shift_mcand = 1'b1;
      end
      BOOTH_M2: begin
        op.sub         = 1'b1;
        op.shift_mcand = 1'b1;
      end
      BOOTH_M1A, BOOTH_M1B: op.sub = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Control FSM for the shared multiply/divide datapath: one Booth or restoring step per clock.
// Multiply result at request+17, divide at +33, exceptions at +1; a new request always wins.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MULT_STEPS = WIDTH / 2,
  parameter int DIV_STEPS  = WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  multdiv_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_div_q, op_div_d;
  logic             exc_q, exc_d;
  logic             req, illegal, div_zero;
  booth_op_t        booth;

  booth_decoder u_booth (
    .booth_bits (bus.booth_bits),
    .op         (booth)
  );

  // Requests are ignored while reset is held so every output reads 0
  assign req      = reset & (bus.ctrl_MULT | bus.ctrl_DIV);
  assign illegal  = bus.ctrl_MULT & bus.ctrl_DIV;
  assign div_zero = bus.ctrl_DIV & ~bus.ctrl_MULT & bus.divisor_zero;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
      exc_q    <= exc_d;
    end
  end

  always_comb begin
    state_d                = state_q;
    cnt_d                  = cnt_q;
    op_div_d               = op_div_q;
    exc_d                  = exc_q;
    bus.load_operands      = 1'b0;
    bus.op_is_div          = op_div_q;
    bus.add                = 1'b0;
    bus.sub                = 1'b0;
    bus.shift_multiplicand = 1'b0;
    bus.shift_product      = 1'b0;
    bus.div_restore        = 1'b0;
    bus.quotient_bit       = 1'b0;
    bus.busy               = (state_q == ST_MULT) || (state_q == ST_DIV);
    bus.data_resultRDY     = 1'b0;
    bus.data_exception     = 1'b0;
    bus.step_count         = cnt_q;

    case (state_q)
      ST_MULT: begin
        bus.add                = booth.add;
        bus.sub                = booth.sub;
        bus.shift_multiplicand = booth.shift_mcand;
        bus.shift_product      = 1'b1;
        cnt_d                  = cnt_q + 1'b1;
        if (cnt_q == MULT_LAST) state_d = ST_DONE;
      end
      ST_DIV: begin
        bus.sub           = 1'b1;
        bus.shift_product = 1'b1;
        bus.div_restore   = bus.rem_negative;
        bus.quotient_bit  = ~bus.rem_negative;
        cnt_d             = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        bus.data_resultRDY = 1'b1;
        bus.data_exception = exc_q | (~op_div_q & bus.mult_overflow);
        state_d            = ST_IDLE;
      end
      default: ;
    endcase

    // A request aborts any step in flight; the datapath only loads this cycle
    if (req) begin
      bus.add                = 1'b0;
      bus.sub                = 1'b0;
      bus.shift_multiplicand = 1'b0;
      bus.shift_product      = 1'b0;
      bus.div_restore        = 1'b0;
      bus.quotient_bit       = 1'b0;
      bus.load_operands      = ~illegal;
      op_div_d               = bus.ctrl_DIV & ~illegal;
      bus.op_is_div          = op_div_d;
      exc_d                  = illegal | div_zero;
      cnt_d                  = '0;
      if (illegal || div_zero) state_d = ST_DONE;
      else if (bus.ctrl_MULT)  state_d = ST_MULT;
      else                     state_d = ST_DIV;
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: latency-based reference model plus directed scenarios.
module tb_multdiv_sequencer;

  localparam int MS = 16;
  localparam int DS = 32;
  localparam int K_NONE = 0, K_MULT = 1, K_DIV = 2, K_EXC = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  multdiv_sequencer_if bus ();

  multdiv_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int kind = K_NONE;
  int age = 0;
  bit mdiv = 1'b0;
  int rdy_cnt = 0;
  int rdy_cyc = -1;
  bit rdy_exc = 1'b0;
  int t0 = 0;
  int t1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int last_age(input int k);
    case (k)
      K_MULT:  return MS + 1;
      K_DIV:   return DS + 1;
      default: return 1;
    endcase
  endfunction

  always @(posedge clock) cyc++;

  // Model: which operation was last accepted and how many cycles ago
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      kind = K_NONE;
      age  = 0;
      mdiv = 1'b0;
    end else if (bus.ctrl_MULT || bus.ctrl_DIV) begin
      age = 1;
      if (bus.ctrl_MULT && bus.ctrl_DIV) begin
        kind = K_EXC; mdiv = 1'b0;
      end else if (bus.ctrl_MULT) begin
        kind = K_MULT; mdiv = 1'b0;
      end else begin
        kind = bus.divisor_zero ? K_EXC : K_DIV; mdiv = 1'b1;
      end
    end else if (kind != K_NONE) begin
      if (age >= last_age(kind)) kind = K_NONE;
      else age++;
    end
  end

  always @(negedge clock) begin
    bit req, stp, dn;
    bit e_add, e_sub, e_shm, e_shp, e_rst, e_q, e_div, e_exc;
    int v;
    if (!reset) begin
      chk("rst_load", 32'(bus.load_operands), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_rdy", 32'(bus.data_resultRDY), 0);
      chk("rst_shp", 32'(bus.shift_product), 0);
      chk("rst_step", 32'(bus.step_count), 0);
    end else begin
      req = bus.ctrl_MULT || bus.ctrl_DIV;
      stp = (kind == K_MULT && age <= MS) || (kind == K_DIV && age <= DS);
      dn  = (kind != K_NONE) && (age == last_age(kind));
      {e_add, e_sub, e_shm, e_shp, e_rst, e_q} = '0;
      if (stp && !req) begin
        e_shp = 1'b1;
        if (kind == K_MULT) begin
          v = -2 * int'(bus.booth_bits[2]) + int'(bus.booth_bits[1]) + int'(bus.booth_bits[0]);
          e_add = v > 0;
          e_sub = v < 0;
          e_shm = (v == 2) || (v == -2);
        end else begin
          e_sub = 1'b1;
          e_rst = bus.rem_negative;
          e_q   = !bus.rem_negative;
        end
      end
      e_div = req ? (bus.ctrl_DIV && !bus.ctrl_MULT) : mdiv;
      e_exc = dn && (kind == K_EXC || (kind == K_MULT && bus.mult_overflow));
      chk("load", 32'(bus.load_operands), 32'(req && !(bus.ctrl_MULT && bus.ctrl_DIV)));
      chk("op_is_div", 32'(bus.op_is_div), 32'(e_div));
      chk("add", 32'(bus.add), 32'(e_add));
      chk("sub", 32'(bus.sub), 32'(e_sub));
      chk("shift_mcand", 32'(bus.shift_multiplicand), 32'(e_shm));
      chk("shift_prod", 32'(bus.shift_product), 32'(e_shp));
      chk("restore", 32'(bus.div_restore), 32'(e_rst));
      chk("qbit", 32'(bus.quotient_bit), 32'(e_q));
      chk("busy", 32'(bus.busy), 32'(stp));
      chk("rdy", 32'(bus.data_resultRDY), 32'(dn));
      chk("exception", 32'(bus.data_exception), 32'(e_exc));
      if (stp) chk("step_count", 32'(bus.step_count), 32'(age - 1));
      if (bus.data_resultRDY) begin
        rdy_cnt++;
        rdy_cyc = cyc;
        rdy_exc = bus.data_exception;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input bit m, input bit d, input bit dz);
    rdy_cnt = 0;
    rdy_cyc = -1;
    bus.ctrl_MULT    = m;
    bus.ctrl_DIV     = d;
    bus.divisor_zero = dz;
    t0 = cyc;
    tick();
    bus.ctrl_MULT    = 1'b0;
    bus.ctrl_DIV     = 1'b0;
    bus.divisor_zero = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.booth_bits = 3'b000;
    bus.rem_negative = 1'b0;
    bus.divisor_zero = 1'b0;
    bus.mult_overflow = 1'b0;
    repeat (3) tick();
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_op_is_div", 32'(bus.op_is_div), 0);
    chk("reset_step", 32'(bus.step_count), 0);
    reset = 1'b1;
    repeat (2) tick();

    // Multiply with constant +2M digit
    bus.booth_bits = 3'b011;
    start(1'b1, 1'b0, 1'b0);
    #3;
    chk("mult_c1_add", 32'(bus.add), 1);
    chk("mult_c1_shm", 32'(bus.shift_multiplicand), 1);
    repeat (15) tick();
    #3;
    chk("mult_c16_step", 32'(bus.step_count), 15);
    repeat (5) tick();
    chk("mult_rdy_cnt", 32'(rdy_cnt), 1);
    chk("mult_rdy_lat", 32'(rdy_cyc - t0), 17);
    chk("mult_rdy_exc", 32'(rdy_exc), 0);

    // Multiply walking all Booth triplets, overflow reported at completion
    start(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bus.booth_bits = 3'(i);
      bus.mult_overflow = 1'b1;
      tick();
    end
    bus.mult_overflow = 1'b0;
    chk("ovf_rdy_lat", 32'(rdy_cyc - t0), 17);
    chk("ovf_exc", 32'(rdy_exc), 1);

    // Divide with alternating remainder sign
    start(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 36; i++) begin
      bus.rem_negative = i[0];
      tick();
    end
    bus.rem_negative = 1'b0;
    chk("div_rdy_cnt", 32'(rdy_cnt), 1);
    chk("div_rdy_lat", 32'(rdy_cyc - t0), 33);
    chk("div_rdy_exc", 32'(rdy_exc), 0);

    // Divide by zero
    start(1'b0, 1'b1, 1'b1);
    repeat (4) tick();
    chk("dz_rdy_cnt", 32'(rdy_cnt), 1);
    chk("dz_rdy_lat", 32'(rdy_cyc - t0), 1);
    chk("dz_exc", 32'(rdy_exc), 1);

    // Simultaneous multiply and divide request
    start(1'b1, 1'b1, 1'b0);
    repeat (4) tick();
    chk("ill_rdy_lat", 32'(rdy_cyc - t0), 1);
    chk("ill_exc", 32'(rdy_exc), 1);

    // Divide request aborts a multiply at cycle 5
    start(1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    bus.ctrl_DIV = 1'b1;
    #3;
    chk("abort_load", 32'(bus.load_operands), 1);
    chk("abort_op_is_div", 32'(bus.op_is_div), 1);
    tick();
    bus.ctrl_DIV = 1'b0;
    repeat (40) tick();
    chk("abort_rdy_cnt", 32'(rdy_cnt), 1);
    chk("abort_rdy_lat", 32'(rdy_cyc - t0), 38);

    // Reset mid-multiply at step 7
    bus.booth_bits = 3'b011;
    start(1'b1, 1'b0, 1'b0);
    repeat (7) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_add", 32'(bus.add), 0);
    chk("midrst_shp", 32'(bus.shift_product), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_step", 32'(bus.step_count), 0);
    tick();
    reset = 1'b1;
    repeat (20) tick();
    chk("midrst_no_rdy", 32'(rdy_cnt), 0);
    start(1'b1, 1'b0, 1'b0);
    repeat (20) tick();
    chk("postrst_rdy_lat", 32'(rdy_cyc - t0), 17);

    // New divide accepted in the same cycle as the multiply result
    start(1'b1, 1'b0, 1'b0);
    repeat (16) tick();
    bus.ctrl_DIV = 1'b1;
    t1 = cyc;
    #3;
    chk("chain_rdy", 32'(bus.data_resultRDY), 1);
    chk("chain_load", 32'(bus.load_operands), 1);
    tick();
    bus.ctrl_DIV = 1'b0;
    repeat (36) tick();
    chk("chain_rdy_cnt", 32'(rdy_cnt), 2);
    chk("chain_rdy_lat", 32'(rdy_cyc - t1), 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
Control FSM that sequences the shared multiply/divide datapath (product/remainder register, multiplicand/divisor register, 32-bit add/sub ALU).
- Accepts single-cycle ctrl_MULT / ctrl_DIV requests.
- Steps radix-4 Booth multiplication or restoring division one iteration per clock.
- Raises data_resultRDY with data_exception at completion.
- Sits between the processor's multdiv request interface and the datapath; replaces free-running countdown control with an explicit state machine.

Parameters:
WIDTH, 32, operand width
MULT_STEPS, 16, Booth radix-4 iterations (WIDTH/2)
DIV_STEPS, 32, restoring-division iterations (WIDTH)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
ctrl_MULT  input  1  one-cycle pulse: start multiply
ctrl_DIV  input  1  one-cycle pulse: start divide
booth_bits  input  3  product register bits [1:0] plus extra low bit, from datapath
rem_negative  input  1  sign of current trial remainder (ALU result MSB)
divisor_zero  input  1  operand B == 0, valid in the request cycle
mult_overflow  input  1  product upper half != sign-extension of lower half
load_operands  output  1  datapath loads operands/clears product this cycle
op_is_div  output  1  datapath mux select: 1 = divide path
add  output  1  ALU add this step
sub  output  1  ALU subtract this step
shift_multiplicand  output  1  select 2x multiplicand (Booth ±2)
shift_product  output  1  shift product/remainder this step
div_restore  output  1  discard trial subtraction, keep old remainder
quotient_bit  output  1  bit shifted into quotient LSB
busy  output  1  operation in progress
data_resultRDY  output  1  one-cycle result-valid pulse
data_exception  output  1  qualifies data_resultRDY
step_count  output  6  current iteration index (debug/verif)

Behaviour:
- Reset (reset=0, async): state IDLE, step_count=0, op_is_div=0. All outputs 0.
- States: IDLE, MULT, DIV, DONE.
- Request acceptance, in IDLE or DONE:
  - ctrl_MULT alone: load_operands=1 combinationally that cycle; next state MULT, step_count=0.
  - ctrl_DIV alone, divisor_zero=0: load_operands=1; next state DIV.
  - ctrl_DIV with divisor_zero=1: load_operands=1; next state DONE with exception latched (RDY one cycle later).
  - ctrl_MULT and ctrl_DIV together: illegal. Next state DONE, exception latched, no datapath activity.
- MULT, each cycle (one Booth step), shift_product=1:
  - booth_bits 000/111: no add/sub.
  - 001/010: add.
  - 011: add with shift_multiplicand=1.
  - 100: sub with shift_multiplicand=1.
  - 101/110: sub.
  - step_count increments; after step MULT_STEPS-1, next state DONE.
- DIV, each cycle: shift_product=1, sub=1 (trial subtract).
  - div_restore = rem_negative.
  - quotient_bit = !rem_negative.
  - After step DIV_STEPS-1, next state DONE.
- DONE, one cycle: data_resultRDY=1.
  - data_exception = latched exception OR (mult op AND mult_overflow).
  - Next state IDLE, unless a new request is accepted this same cycle.
- Latency, counting the request cycle as cycle 0:
  - multiply: RDY at cycle MULT_STEPS+1 = 17.
  - divide: RDY at cycle 33.
  - div-by-zero or illegal request: RDY at cycle 1.
- busy=1 in MULT and DIV only.
- New ctrl_MULT/ctrl_DIV while busy: abort the current operation (no RDY for it) and restart per the acceptance rules. Latency is counted from the new request.
- reset mid-operation: immediate return to IDLE. No RDY pulse.
- add, sub, shift_* are never asserted in IDLE or DONE. add and sub are never both 1.
- op_is_div is held constant from load through DONE.

Decomposition:
- Shared package multdiv_pkg:
  - state encoding (IDLE=2'b00, MULT=2'b01, DIV=2'b10, DONE=2'b11).
  - Booth decode constants.
  - MULT_STEPS/DIV_STEPS defaults.
- One natural sub-module: booth_decoder (combinational, booth_bits -> add/sub/shift_multiplicand).
- Counter and FSM stay in multdiv_sequencer.

Test Plan:
- ctrl_MULT pulse, booth_bits held 011 -> load_operands at cycle 0; add=1, shift_multiplicand=1, shift_product=1 for cycles 1-16; data_resultRDY=1 only at cycle 17; data_exception=0.
- ctrl_DIV, divisor_zero=0, rem_negative alternating 0/1 -> sub=1 in cycles 1-32; quotient_bit=!rem_negative and div_restore=rem_negative each cycle; RDY at cycle 33.
- ctrl_DIV with divisor_zero=1 -> no sub/shift ever; RDY=1 and data_exception=1 at cycle 1; IDLE at cycle 2.
- ctrl_MULT with mult_overflow=1 during DONE -> RDY and data_exception both 1 at cycle 17; ctrl_MULT+ctrl_DIV together -> RDY and exception at cycle 1.
- ctrl_MULT, then ctrl_DIV at cycle 5 -> load_operands at 5; no RDY at 17; RDY at 38; op_is_div=1 from cycle 5.
- reset=0 asserted mid-MULT at step 7 (between edges) -> all outputs 0 immediately; no RDY; after release a new ctrl_MULT completes in 17 cycles.
